vga_timing_ctrl: RTL and testbench

Generates 640×480@60 Hz VGA raster timing from a 25 MHz pixel clock. Drives `pix_x`/`pix_y` to the frame painter and receives the painted `rgb` back. Delays sync and blanking by the painter's ROM pipeline depth so colour and sync reach the connector aligned. Also emits a once-per-frame tick so game logic can update object positions during vertical blanking.

---
 rtl/vga_timing_ctrl.sv | 119 +++++++++++
 tb/tb_vga_timing_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing (640x480@60 at 25 MHz) with sync/blank delayed to match the painter latency.
// Optional build macro VGA_TEST_PATTERN_EN replaces rgb_in with eight built-in colour bars.
module vga_timing_ctrl #(
  parameter int PIPE_LAT = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_rgb_in,
  output logic [9:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic        o_video_on,
  output logic        o_frame_tick,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic [11:0] o_vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
`ifdef VGA_TEST_PATTERN_EN
  localparam int SW = 15;
`else
  localparam int SW = 3;
`endif
  // Stage layout: {colour (pattern build only), hs, vs, de}; idle is syncs high, de low, black.
  localparam logic [SW-1:0] STAGE_IDLE = SW'(3'b110);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_h_act;
  logic       w_v_act;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [SW-1:0] w_stage_in;
  logic [SW-1:0] w_tap [0:PIPE_LAT];
  logic [SW-1:0] w_dly;
  logic [11:0]   w_dly_rgb;

  assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_last) begin
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end
    end
  end

  assign w_h_act      = (r_h_cnt < 10'(H_ACTIVE));
  assign w_v_act      = (r_v_cnt < 10'(V_ACTIVE));
  assign o_pix_x      = w_h_act ? r_h_cnt : 10'd0;
  assign o_pix_y      = w_v_act ? r_v_cnt[8:0] : 9'd0;
  assign o_video_on   = w_h_act && w_v_act;
  assign o_frame_tick = (r_h_cnt == 10'd0) && (r_v_cnt == 10'(V_ACTIVE));

  assign w_hs_raw = !((r_h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                      (r_h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs_raw = !((r_v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                      (r_v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  w_bar;
  logic [11:0] w_bar_rgb;
  // Bars past the active width wrap, but those pixels are blanked anyway.
  assign w_bar      = 3'(r_h_cnt / 10'd80);
  assign w_bar_rgb  = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
  assign w_stage_in = {w_bar_rgb, w_hs_raw, w_vs_raw, o_video_on};
  assign w_dly_rgb  = w_dly[14:3];
`else
  assign w_stage_in = {w_hs_raw, w_vs_raw, o_video_on};
  assign w_dly_rgb  = i_rgb_in;
`endif

  assign w_tap[0] = w_stage_in;

  generate
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
      logic [SW-1:0] r_stage;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_stage <= STAGE_IDLE;
        end else begin
          r_stage <= w_tap[gi];
        end
      end
      assign w_tap[gi+1] = r_stage;
    end
  endgenerate

  assign w_dly = w_tap[PIPE_LAT];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_vga_hs  <= 1'b1;
      o_vga_vs  <= 1'b1;
      o_vga_rgb <= 12'h000;
    end else begin
      o_vga_hs  <= w_dly[2];
      o_vga_vs  <= w_dly[1];
      o_vga_rgb <= w_dly[0] ? w_dly_rgb : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl; vertical timing is shortened to keep runs small.
// Expected outputs are pushed per issued coordinate and popped PIPE_LAT+1 cycles later.
module tb_vga_timing_ctrl;

  localparam int L     = 1;
  localparam int HA    = 640;
  localparam int HFP   = 16;
  localparam int HS    = 96;
  localparam int HT    = 800;
  localparam int VA    = 8;
  localparam int VFP   = 2;
  localparam int VS    = 2;
  localparam int VT    = 15;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rgb_in;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        video_on;
  logic        frame_tick;
  logic        vga_hs;
  logic        vga_vs;
  logic [11:0] vga_rgb;

  vga_timing_ctrl #(
    .PIPE_LAT(L), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(48),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rgb_in(rgb_in),
    .o_pix_x(pix_x), .o_pix_y(pix_y), .o_video_on(video_on),
    .o_frame_tick(frame_tick), .o_vga_hs(vga_hs), .o_vga_vs(vga_vs),
    .o_vga_rgb(vga_rgb)
  );

  always #20 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [13:0] sb[$];
  int          t;
  int          last_tick;
  logic        prev_hs, prev_vs;
  int          hs_low, vs_low;
  bit          force_white = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic release_model();
    t = 0;
    last_tick = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    hs_low = 0;
    vs_low = 0;
    sb.delete();
    repeat (L + 1) sb.push_back({1'b1, 1'b1, 12'h000});
  endtask

  task automatic sample();
    int          mh, mv;
    logic        de, hs_e, vs_e;
    logic [11:0] col;
    logic [13:0] e;
    logic [2:0]  k;
    mh = t % HT;
    mv = (t / HT) % VT;
    de = (mh < HA) && (mv < VA);
    check("pix_x", 32'(pix_x), (mh < HA) ? 32'(mh) : 32'd0);
    check("pix_y", 32'(pix_y), (mv < VA) ? 32'(mv) : 32'd0);
    check("video_on", 32'(video_on), 32'(de));
    check("frame_tick", 32'(frame_tick), 32'((mh == 0) && (mv == VA)));
    if (frame_tick) begin
      if (last_tick < 0) check("first_tick", 32'(t), 32'(VA * HT));
      else check("tick_period", 32'(t - last_tick), 32'(FRAME));
      last_tick = t;
    end
    e = sb.pop_front();
    check("vga_hs", 32'(vga_hs), 32'(e[13]));
    check("vga_vs", 32'(vga_vs), 32'(e[12]));
    check("vga_rgb", 32'(vga_rgb), 32'(e[11:0]));
    if (prev_hs && !vga_hs) check("hs_fall_pos", 32'(t % HT), 32'(HA + HFP + L + 1));
    if (!vga_hs) hs_low++;
    else if (!prev_hs) begin
      check("hs_low_len", 32'(hs_low), 32'(HS));
      hs_low = 0;
    end
    if (!vga_vs) vs_low++;
    else if (!prev_vs) begin
      check("vs_low_len", 32'(vs_low), 32'(VS * HT));
      vs_low = 0;
    end
    prev_hs = vga_hs;
    prev_vs = vga_vs;
    hs_e = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
    vs_e = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
`ifdef VGA_TEST_PATTERN_EN
    k = 3'(mh / 80);
    col = {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
`else
    k = 3'd0;
    col = force_white ? 12'hFFF : {4'(mh), 4'(mv), 4'hA};
`endif
    sb.push_back({hs_e, vs_e, de ? col : 12'h000});
  endtask

  // Painter model: one register from pix_x/pix_y to rgb_in.
  task automatic advance();
    logic [11:0] nxt;
`ifdef VGA_TEST_PATTERN_EN
    nxt = 12'h000;
`else
    nxt = force_white ? 12'hFFF : {pix_x[3:0], pix_y[3:0], 4'hA};
`endif
    @(posedge clk);
    #1;
    rgb_in = nxt;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      advance();
      t++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hs"}, 32'(vga_hs), 32'd1);
    check({tag, "_vs"}, 32'(vga_vs), 32'd1);
    check({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
    check({tag, "_tick"}, 32'(frame_tick), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    rgb_in = 12'h000;
    t      = 0;
    $display("[TB] step 1: reset held 10 cycles");
    repeat (10) advance();
    check_reset_state("reset");
    rst_n = 1'b1;
    release_model();

    $display("[TB] step 2: frame 1, painter pattern");
    run(FRAME);
    $display("[TB] step 3: frame 2, painter forced to FFF");
    force_white = 1'b1;
    run(FRAME + 10);
    force_white = 1'b0;

    $display("[TB] step 4: run to sync line, h=700");
    run(2 * FRAME + (VA + VFP + 1) * HT + 700 - t);
    sample();
    rst_n = 1'b0;
    advance();
    check_reset_state("midreset");
    rst_n = 1'b1;
    release_model();

    $display("[TB] step 5: post-reset run to first frame tick");
    run(VA * HT + 20);
    check("tick_seen_after_reset", 32'(last_tick), 32'(VA * HT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
